// File: rtl/orientation_fifo_write_scheduler_pkg.sv
// Shared constants and state type for the orientation FIFO write scheduler.
// AF_THRESH leaves room for one full burst plus a small margin below FIFO depth.
package orientation_sched_pkg;
  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 128;
  localparam int BURST_LEN  = 16;
  localparam int USEDW_W    = 8;
  localparam int FIFO_DEPTH = 256;
  localparam int AF_MARGIN  = 4;
  localparam int AF_THRESH  = FIFO_DEPTH - BURST_LEN - AF_MARGIN;

  typedef enum logic {
    IDLE,
    XFER
  } state_t;
endpackage

// File: rtl/orientation_fifo_write_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester found searching upward from ptr+1.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             any
);
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (req[idx[PTR_W-1:0]] && (grant == '0))
        grant[idx[PTR_W-1:0]] = 1'b1;
    end
    any = |req;
  end
endmodule

// File: rtl/orientation_fifo_write_scheduler.sv
// Write-side scheduler sharing one DCFIFO write port among NUM_REQ producers,
// round-robin at burst granularity with fill-level admission control.
module orientation_fifo_write_scheduler #(
  parameter int NUM_REQ   = orientation_sched_pkg::NUM_REQ,
  parameter int DATA_W    = orientation_sched_pkg::DATA_W,
  parameter int BURST_LEN = orientation_sched_pkg::BURST_LEN,
  parameter int USEDW_W   = orientation_sched_pkg::USEDW_W,
  parameter int AF_THRESH = orientation_sched_pkg::AF_THRESH
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      ienable,
  input  logic [NUM_REQ-1:0]        ivalid,
  input  logic [NUM_REQ*DATA_W-1:0] idata,
  output logic [NUM_REQ-1:0]        oready,
  input  logic [USEDW_W-1:0]        iwrusedw,
  input  logic                      iwrfull,
  output logic                      owrreq,
  output logic [DATA_W-1:0]         odata,
  output logic [NUM_REQ-1:0]        ogrant,
  output logic [15:0]               oburst_count,
  output logic                      obusy
);
  import orientation_sched_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_any;
  logic [DATA_W-1:0]  sel_data;
  logic [PTR_W-1:0]   g_idx;
  logic               hs;
  logic               admit;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (ivalid),
    .ptr   (ptr),
    .grant (arb_grant),
    .any   (arb_any)
  );

  // Full gating is defensive; admission already reserves room for the burst.
  always_comb begin
    oready = (state == XFER && !iwrfull) ? ogrant : '0;
  end

  always_comb begin
    sel_data = '0;
    g_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ogrant[i]) begin
        sel_data = idata[i*DATA_W +: DATA_W];
        g_idx    = PTR_W'(i);
      end
    end
  end

  assign hs    = |(ivalid & oready);
  assign admit = ienable && arb_any && (iwrusedw < USEDW_W'(AF_THRESH));
  assign obusy = (state == XFER);

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state        <= IDLE;
      ptr          <= PTR_W'(NUM_REQ - 1);
      cnt          <= '0;
      ogrant       <= '0;
      owrreq       <= 1'b0;
      odata        <= '0;
      oburst_count <= '0;
    end else begin
      owrreq <= 1'b0;
      case (state)
        IDLE: begin
          if (admit) begin
            ogrant <= arb_grant;
            cnt    <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (hs) begin
            owrreq <= 1'b1;
            odata  <= sel_data;
            if (cnt == CNT_W'(BURST_LEN - 1)) begin
              state        <= IDLE;
              ogrant       <= '0;
              ptr          <= g_idx;
              oburst_count <= oburst_count + 16'd1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_orientation_fifo_write_scheduler.sv
// Self-checking bench: transaction-level reference model, constant vector table,
// directed corner-case sequences and a randomized phase.
module tb_orientation_fifo_write_scheduler;
  localparam int NR = 4;
  localparam int DW = 128;
  localparam int BL = 16;
  localparam int TH = 236;

  logic              iclk = 1'b0;
  logic              ireset;
  logic              ienable;
  logic [NR-1:0]     ivalid;
  logic [NR*DW-1:0]  idata;
  logic [NR-1:0]     oready;
  logic [7:0]        iwrusedw;
  logic              iwrfull;
  logic              owrreq;
  logic [DW-1:0]     odata;
  logic [NR-1:0]     ogrant;
  logic [15:0]       oburst_count;
  logic              obusy;

  orientation_fifo_write_scheduler dut (
    .iclk         (iclk),
    .ireset       (ireset),
    .ienable      (ienable),
    .ivalid       (ivalid),
    .idata        (idata),
    .oready       (oready),
    .iwrusedw     (iwrusedw),
    .iwrfull      (iwrfull),
    .owrreq       (owrreq),
    .odata        (odata),
    .ogrant       (ogrant),
    .oburst_count (oburst_count),
    .obusy        (obusy)
  );

  always #5 iclk = ~iclk;

  int total = 0;
  int bad   = 0;

  // Reference model: which lane owns the port, how many words it has moved,
  // who was served last, and the completed-burst tally.
  int          m_owner;
  int          m_done;
  int          m_last;
  int          m_count;
  logic        m_wrreq;
  logic [DW-1:0] m_data;
  int          lane_word [NR];
  bit          rand_data;

  int          grant_log [$];
  logic [DW-1:0] wr_log [$];
  int          wr_pulses;

  typedef struct {
    logic [NR-1:0] valid;
    logic [7:0]    usedw;
    logic          en;
    logic          full;
    logic [NR-1:0] exp_grant;
    logic          exp_wrreq;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_data();
    for (int i = 0; i < NR; i++) begin
      if (rand_data)
        idata[i*DW +: DW] = {$urandom, $urandom, 32'h0, 32'(i*256 + lane_word[i] + 1)};
      else
        idata[i*DW +: DW] = DW'(i*256 + lane_word[i] + 1);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_done  = 0;
    m_last  = NR - 1;
    m_count = 0;
    m_wrreq = 1'b0;
    m_data  = '0;
    for (int i = 0; i < NR; i++) lane_word[i] = 0;
  endtask

  task automatic check_outputs();
    chk("owrreq", DW'(owrreq), DW'(m_wrreq));
    chk("odata", odata, m_data);
    chk("ogrant", DW'(ogrant), (m_owner < 0) ? '0 : DW'(1) << m_owner);
    chk("oburst_count", DW'(oburst_count), DW'(m_count));
    chk("obusy", DW'(obusy), DW'(m_owner >= 0));
  endtask

  // One clock: check combinational ready, predict, clock, check registered outputs.
  task automatic step();
    logic [NR-1:0] er;
    logic [NR-1:0] prev_grant;
    int winner;
    #1;
    er = (m_owner >= 0 && !iwrfull) ? NR'(1) << m_owner : '0;
    chk("oready", DW'(oready), DW'(er));
    prev_grant = ogrant;
    m_wrreq = 1'b0;
    if (m_owner < 0) begin
      winner = -1;
      if (ienable && ivalid != '0 && iwrusedw < TH) begin
        for (int k = 1; k <= NR; k++)
          if (winner < 0 && ivalid[(m_last + k) % NR]) winner = (m_last + k) % NR;
      end
      if (winner >= 0) begin
        m_owner = winner;
        m_done  = 0;
      end
    end else if (ivalid[m_owner] && !iwrfull) begin
      m_wrreq = 1'b1;
      m_data  = idata[m_owner*DW +: DW];
      lane_word[m_owner] = (lane_word[m_owner] + 1) % BL;
      m_done++;
      if (m_done == BL) begin
        m_last  = m_owner;
        m_owner = -1;
        m_count = (m_count + 1) % 65536;
      end
    end
    @(posedge iclk);
    #1;
    check_outputs();
    if (prev_grant == '0 && ogrant != '0)
      for (int i = 0; i < NR; i++) if (ogrant[i]) grant_log.push_back(i);
    if (owrreq) begin
      wr_pulses++;
      wr_log.push_back(odata);
    end
    build_data();
  endtask

  task automatic do_reset();
    ireset = 1'b1;
    model_reset();
    build_data();
    @(posedge iclk);
    #1;
    check_outputs();
    chk("reset_oready", DW'(oready), '0);
    ireset = 1'b0;
    grant_log.delete();
    wr_log.delete();
    wr_pulses = 0;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    while (m_owner >= 0 && n < budget) begin
      step();
      n++;
    end
    if (m_owner >= 0) chk({name, "_timeout"}, DW'(1), DW'(0));
  endtask

  initial begin
    ireset = 1'b1; ienable = 1'b0; ivalid = '0; iwrusedw = '0; iwrfull = 1'b0;
    rand_data = 1'b0;
    model_reset();
    build_data();
    #3;
    chk("async_reset_owrreq", DW'(owrreq), '0);
    chk("async_reset_ogrant", DW'(ogrant), '0);
    @(posedge iclk);
    #1;

    // Test 1: single lane, words 0x1..0x10.
    do_reset();
    ienable = 1'b1; ivalid = 4'b0001;
    step();
    chk("t1_grant", DW'(ogrant), DW'(4'b0001));
    for (int n = 0; n < 40 && m_owner >= 0; n++) step();
    ivalid = '0;
    step();
    chk("t1_words", DW'(wr_log.size()), DW'(BL));
    for (int k = 0; k < wr_log.size() && k < BL; k++) chk("t1_odata", wr_log[k], DW'(k + 1));
    chk("t1_count", DW'(oburst_count), DW'(1));
    chk("t1_idle", DW'(obusy), '0);

    // Test 2: all lanes valid, five bursts.
    do_reset();
    ienable = 1'b1; ivalid = 4'b1111;
    for (int n = 0; n < 5 * (BL + 1); n++) step();
    chk("t2_bursts", DW'(grant_log.size()), DW'(5));
    for (int k = 0; k < grant_log.size() && k < 5; k++) chk("t2_order", DW'(grant_log[k]), DW'(k % NR));
    chk("t2_pulses", DW'(wr_pulses), DW'(5 * BL));
    chk("t2_count", DW'(oburst_count), DW'(5));
    ivalid = '0;
    step();

    // Test 3: admission threshold and idle gating, table-driven.
    do_reset();
    vecs.push_back('{4'b0100, 8'd236, 1'b1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{4'b0100, 8'd255, 1'b1, 1'b1, 4'b0000, 1'b0});
    vecs.push_back('{4'b0000, 8'd0,   1'b1, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{4'b0100, 8'd0,   1'b0, 1'b0, 4'b0000, 1'b0});
    vecs.push_back('{4'b0100, 8'd235, 1'b1, 1'b0, 4'b0100, 1'b0});
    vecs.push_back('{4'b0100, 8'd255, 1'b0, 1'b0, 4'b0100, 1'b1});
    for (int v = 0; v < vecs.size(); v++) begin
      ivalid = vecs[v].valid; iwrusedw = vecs[v].usedw;
      ienable = vecs[v].en;   iwrfull = vecs[v].full;
      step();
      chk("t3_ogrant", DW'(ogrant), DW'(vecs[v].exp_grant));
      chk("t3_owrreq", DW'(owrreq), DW'(vecs[v].exp_wrreq));
    end
    iwrusedw = '0; iwrfull = 1'b0; ienable = 1'b1;
    run_until_idle("t3", 40);

    // Test 4: lane 1 stalls at word 7, iwrfull pulse, others must wait.
    do_reset();
    ienable = 1'b1; ivalid = 4'b0010;
    step();
    ivalid = 4'b1111;
    for (int n = 0; n < 20 && m_done < 7; n++) step();
    ivalid = 4'b1101;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t4_gap_owrreq", DW'(owrreq), '0);
    end
    ivalid = 4'b1111;
    step();
    iwrfull = 1'b1;
    for (int n = 0; n < 2; n++) begin
      #1;
      chk("t4_full_ready", DW'(oready), '0);
      step();
      chk("t4_full_owrreq", DW'(owrreq), '0);
    end
    iwrfull = 1'b0;
    run_until_idle("t4", 40);
    chk("t4_pulses", DW'(wr_pulses), DW'(BL));
    chk("t4_only_lane1", DW'(grant_log.size()), DW'(1));
    ivalid = '0;
    step();

    // Test 5: asynchronous reset at word 9.
    do_reset();
    ienable = 1'b1; ivalid = 4'b1111;
    for (int n = 0; n < 60 && !(m_owner == 1 && m_done == 9); n++) step();
    #2;
    ireset = 1'b1;
    #1;
    chk("t5_owrreq", DW'(owrreq), '0);
    chk("t5_ogrant", DW'(ogrant), '0);
    chk("t5_count", DW'(oburst_count), '0);
    chk("t5_obusy", DW'(obusy), '0);
    model_reset();
    build_data();
    @(posedge iclk);
    #1;
    ireset = 1'b0;
    step();
    chk("t5_first_lane0", DW'(ogrant), DW'(4'b0001));
    run_until_idle("t5", 40);

    // Test 6: ienable drops mid-burst.
    do_reset();
    ienable = 1'b1; ivalid = 4'b1000;
    step();
    ivalid = 4'b1111;
    for (int n = 0; n < 20 && m_done < 4; n++) step();
    ienable = 1'b0;
    run_until_idle("t6", 40);
    chk("t6_pulses", DW'(wr_pulses), DW'(BL));
    for (int n = 0; n < 5; n++) step();
    chk("t6_no_grant", DW'(ogrant), '0);
    chk("t6_count", DW'(oburst_count), DW'(1));

    // Randomized phase against the reference model.
    do_reset();
    rand_data = 1'b1;
    build_data();
    for (int n = 0; n < 800; n++) begin
      ivalid   = NR'($urandom_range(0, 15) | (($urandom_range(0, 3) == 0) ? 0 : 4'b0000));
      if ($urandom_range(0, 3) != 0) ivalid = ivalid | NR'(1) << $urandom_range(0, NR - 1);
      iwrusedw = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(230, 255)) : 8'($urandom_range(0, 235));
      ienable  = ($urandom_range(0, 9) != 0);
      iwrfull  = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/orientation_fifo_write_scheduler.md
Name: orientation_fifo_write_scheduler

Overview:
Write-side scheduler for the 128-bit orientation DCFIFO (write domain, 50 MHz). Shares the FIFO write port between NUM_REQ gradient-patch producers, one per keypoint lane. Arbitration is round-robin at burst granularity: each grant moves exactly BURST_LEN words. A new burst is admitted only when the FIFO fill level guarantees room for the whole burst.

Parameters:
NUM_REQ, 4, number of requesting producers
DATA_W, 128, word width (matches FIFO write width)
BURST_LEN, 16, words per grant (one keypoint patch row set)
USEDW_W, 8, width of FIFO write-side used-words count
AF_THRESH, 236, new burst admitted only if iwrusedw < AF_THRESH (256 − BURST_LEN − 4 margin)

Ports:
iclk  in  1  write-domain clock
ireset  in  1  asynchronous reset, active-high
ienable  in  1  allow new bursts; a burst in progress always completes
ivalid  in  NUM_REQ  per-requester word valid
idata  in  NUM_REQ*DATA_W  flattened requester words, lane i at [i*DATA_W +: DATA_W]
oready  out  NUM_REQ  per-requester accept (combinational)
iwrusedw  in  USEDW_W  FIFO write-side used words
iwrfull  in  1  FIFO write-side full
owrreq  out  1  FIFO write request (registered)
odata  out  DATA_W  FIFO write data (registered)
ogrant  out  NUM_REQ  one-hot current owner, zero when idle
oburst_count  out  16  completed bursts, wraps at 65535→0
obusy  out  1  high in XFER

Behaviour:
- Reset: asynchronous, active-high. On reset: state IDLE, owrreq=0, odata=0, ogrant=0, oready=0, oburst_count=0, obusy=0, round-robin pointer=NUM_REQ−1 (lane 0 has first priority).
- States: IDLE, XFER.
- IDLE:
  - Burst starts when ienable=1, |ivalid=1 and iwrusedw < AF_THRESH.
  - Winner is the first lane with ivalid=1, searching from pointer+1 upward modulo NUM_REQ.
  - Next cycle: ogrant=winner one-hot, word counter=0, state XFER.
  - If there are no requests, or iwrusedw ≥ AF_THRESH, or ienable=0: stay in IDLE.
- XFER:
  - oready[i] = ogrant[i] & ~iwrfull. All other lanes see oready=0.
  - A handshake is ivalid[g] & oready[g].
  - On a handshake, the next cycle has owrreq=1 and odata=idata lane g. Latency is 1 cycle.
  - Without a handshake, the next cycle has owrreq=0 and odata holds its previous value.
  - If the producer drops ivalid mid-burst, the block waits in XFER indefinitely with no timeout.
- Burst end:
  - The handshake with counter == BURST_LEN−1 ends the burst.
  - Next cycle: state IDLE, ogrant=0, pointer=g, oburst_count+1.
  - There is at least one IDLE cycle between bursts. Max throughput is BURST_LEN words per BURST_LEN+1 cycles.
- Counter is clog2(BURST_LEN) bits and cleared on burst start.
- Overflow safety:
  - Admission guarantees space for the full burst.
  - iwrfull gating of oready is defensive only.
  - owrreq must never assert while iwrfull was high on the preceding handshake cycle.
- Simultaneous events:
  - ienable falling mid-burst has no effect on the current burst.
  - iwrusedw rising above AF_THRESH mid-burst has no effect on the current burst.
  - A requester asserting ivalid while another lane holds the grant waits; its data must be held by the producer.
- Reset mid-burst: everything clears immediately. Words already written stay in the FIFO, and the producer restarts its patch.
- oburst_count wraps 0xFFFF→0 with no flag.

Decomposition:
- Package orientation_sched_pkg: DATA_W, BURST_LEN, USEDW_W, FIFO depth 256, AF_THRESH derivation, state enum {IDLE, XFER}.
- One sub-module, rr_arbiter: combinational pointer-rotated priority pick. Inputs are request vector and pointer; output is one-hot grant plus any-flag.
- The FSM, counter and output registers live in the top module.

Test Plan:
1. Reset, then lane 0 holds ivalid for 16 words 0x1..0x10 with iwrusedw=0 -> ogrant=0001 one cycle later; owrreq high 16 consecutive cycles with odata 0x1..0x10, each 1 cycle after its handshake; oburst_count=1; then IDLE.
2. All four lanes valid continuously -> grant order 0,1,2,3,0; each burst exactly 16 owrreq pulses; one idle cycle between bursts; oburst_count=5 after 5 bursts.
3. iwrusedw=236 with lane 2 valid -> no grant, owrreq=0; drop iwrusedw to 235 -> grant 0100 next cycle.
4. Lane 1 drops ivalid for 3 cycles at word 7 -> owrreq gap of 3 cycles, burst still totals 16 words, no other lane granted meanwhile; iwrfull pulsed 2 cycles mid-burst -> oready[1]=0 and no owrreq for those handshake slots.
5. Assert ireset at word 9 of a burst -> same-edge clear: owrreq=0, ogrant=0, oburst_count=0; after release, lane 0 wins first.
6. ienable dropped at word 4 -> burst completes all 16 words; no new grant while ienable=0 even with requests pending.
